// File: rtl/write_data_stream_if.sv
// rtl/write_data_stream_if.sv - tile writer control, tile capture and output stream bundle
interface write_data_stream_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int TILING_SIZE = 8,
    parameter int SEL_W       = $clog2(TILING_SIZE),
    parameter int CNT_W       = 16
);
    logic [2:0]                        state;
    logic [CNT_W-1:0]                  counter_tiling;
    logic [TILING_SIZE*DATA_WIDTH-1:0] tile_data;
    logic [SEL_W:0]                    lanes_valid;
    logic                              reverse;
    logic                              out_ready;
    logic                              clr_err;
    logic [DATA_WIDTH-1:0]             data_output;
    logic                              valid_data;
    logic [SEL_W-1:0]                  sel_data;
    logic                              last;
    logic                              busy;
    logic                              tile_done;
    logic                              overflow;

    // Controller / downstream side
    modport master (
        output state, counter_tiling, tile_data, lanes_valid, reverse, out_ready, clr_err,
        input  data_output, valid_data, sel_data, last, busy, tile_done, overflow
    );

    // Tile writer side
    modport slave (
        input  state, counter_tiling, tile_data, lanes_valid, reverse, out_ready, clr_err,
        output data_output, valid_data, sel_data, last, busy, tile_done, overflow
    );
endinterface

// File: rtl/write_data_stream.sv
// rtl/write_data_stream.sv - captures one accumulator tile and streams its lanes over valid/ready
module write_data_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int TILING_SIZE = 8,
    parameter int SEL_W       = $clog2(TILING_SIZE),
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    write_data_stream_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} fsm_e;

    localparam logic [SEL_W:0] TILE_N = (SEL_W+1)'(TILING_SIZE);

    fsm_e                  fsm_q, fsm_d;
    logic                  trig_q;
    logic                  trigger;
    logic                  start;
    logic [DATA_WIDTH-1:0] snap_q [TILING_SIZE];
    logic [SEL_W:0]        n_q;
    logic [SEL_W:0]        n_clamped;
    logic                  rev_q;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      top_idx;
    logic [SEL_W-1:0]      final_idx;
    logic                  at_final;
    logic                  xfer;
    logic                  done_q;
    logic                  ovf_q;

    // Start is the rising edge of the write-phase condition, so a held phase sends one tile
    assign trigger   = (bus.state == 3'd4) && (bus.counter_tiling > CNT_W'(1));
    assign start     = trigger & ~trig_q;
    assign n_clamped = ((bus.lanes_valid == '0) || (bus.lanes_valid > TILE_N)) ? TILE_N : bus.lanes_valid;
    assign top_idx   = SEL_W'(n_q - 1'b1);
    assign final_idx = rev_q ? '0 : top_idx;
    assign at_final  = (sel_q == final_idx);
    assign xfer      = (fsm_q == SEND) && bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state: LOAD is a single settling cycle, SEND exits only on the accepted final lane
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = LOAD;
            LOAD:    fsm_d = SEND;
            SEND:    if (xfer && at_final) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs decoded purely from registers; idle cycles present zeros
    always_comb begin
        bus.valid_data  = (fsm_q == SEND);
        bus.busy        = (fsm_q != IDLE);
        bus.last        = (fsm_q == SEND) && at_final;
        bus.sel_data    = (fsm_q == SEND) ? sel_q : '0;
        bus.data_output = (fsm_q == SEND) ? snap_q[sel_q] : '0;
        bus.tile_done   = done_q;
        bus.overflow    = ovf_q;
    end

    // Tile snapshot, lane count/order latch, lane index stepping and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
            n_q    <= '0;
            rev_q  <= 1'b0;
            sel_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < TILING_SIZE; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            trig_q <= trigger;
            done_q <= xfer && at_final;
            if (fsm_q == IDLE && start) begin
                n_q   <= n_clamped;
                rev_q <= bus.reverse;
                for (int i = 0; i < TILING_SIZE; i++) begin
                    snap_q[i] <= bus.tile_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (fsm_q == LOAD) begin
                sel_q <= rev_q ? top_idx : '0;
            end else if (xfer && !at_final) begin
                sel_q <= rev_q ? sel_q - 1'b1 : sel_q + 1'b1;
            end
            // A dropped trigger sets the flag even when clr_err is asserted alongside
            if (start && fsm_q != IDLE) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_write_data_stream.sv
// tb/tb_write_data_stream.sv - directed self-checking bench for write_data_stream
module tb_write_data_stream;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    write_data_stream_if bus ();

    write_data_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int base);
        for (int i = 0; i < 8; i++) begin
            bus.tile_data[i*16 +: 16] = 16'(base + i);
        end
    endtask

    initial begin
        int         words;
        int         dones;
        int         busy_seen;
        logic [3:0] pat;

        rst                = 1'b1;
        bus.state          = 3'd0;
        bus.counter_tiling = 16'd0;
        bus.tile_data      = '0;
        bus.lanes_valid    = 4'd8;
        bus.reverse        = 1'b0;
        bus.out_ready      = 1'b1;
        bus.clr_err        = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.valid_data), 32'd0);
        chk("rst_data", 32'(bus.data_output), 32'd0);
        chk("rst_sel", 32'(bus.sel_data), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.tile_done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Forward, 8 lanes, no stalls
        set_lanes(1);
        bus.counter_tiling = 16'd2;
        bus.state          = 3'd4;
        tick();
        chk("fwd_load_busy", 32'(bus.busy), 32'd1);
        chk("fwd_load_valid", 32'(bus.valid_data), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fwd_valid", 32'(bus.valid_data), 32'd1);
            chk("fwd_data", 32'(bus.data_output), 32'(i + 1));
            chk("fwd_sel", 32'(bus.sel_data), 32'(i));
            chk("fwd_last", 32'(bus.last), 32'(i == 7));
        end
        tick();
        chk("fwd_done", 32'(bus.tile_done), 32'd1);
        chk("fwd_idle_busy", 32'(bus.busy), 32'd0);
        chk("fwd_idle_valid", 32'(bus.valid_data), 32'd0);
        tick();
        chk("fwd_done_pulse", 32'(bus.tile_done), 32'd0);
        bus.state = 3'd0;
        tick();

        // Reverse, 3 lanes
        bus.reverse     = 1'b1;
        bus.lanes_valid = 4'd3;
        bus.state       = 3'd4;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rev_data", 32'(bus.data_output), 32'(3 - i));
            chk("rev_sel", 32'(bus.sel_data), 32'(2 - i));
            chk("rev_last", 32'(bus.last), 32'(i == 2));
        end
        tick();
        chk("rev_done", 32'(bus.tile_done), 32'd1);
        bus.state       = 3'd0;
        bus.reverse     = 1'b0;
        bus.lanes_valid = 4'd8;
        tick();

        // Backpressure with ready pattern 1,0,0,1 repeating
        pat       = 4'b1001;
        words     = 0;
        bus.state = 3'd4;
        tick();
        tick();
        for (int c = 0; c < 40 && words < 8; c++) begin
            bus.out_ready = pat[c % 4];
            chk("stall_valid", 32'(bus.valid_data), 32'd1);
            chk("stall_data", 32'(bus.data_output), 32'(words + 1));
            chk("stall_sel", 32'(bus.sel_data), 32'(words));
            if (bus.out_ready) words++;
            tick();
        end
        chk("stall_words", 32'(words), 32'd8);
        chk("stall_done", 32'(bus.tile_done), 32'd1);
        bus.out_ready = 1'b1;
        bus.state     = 3'd0;
        tick();

        // Held write phase sends exactly one tile
        words     = 0;
        dones     = 0;
        bus.state = 3'd4;
        repeat (20) begin
            tick();
            if (bus.valid_data && bus.out_ready) words++;
            if (bus.tile_done) dones++;
        end
        chk("hold_words", 32'(words), 32'd8);
        chk("hold_dones", 32'(dones), 32'd1);
        bus.state = 3'd0;
        tick();

        // counter_tiling of 1 never triggers
        bus.counter_tiling = 16'd1;
        bus.state          = 3'd4;
        words              = 0;
        busy_seen          = 0;
        repeat (12) begin
            tick();
            if (bus.valid_data) words++;
            if (bus.busy) busy_seen++;
        end
        chk("cnt1_words", 32'(words), 32'd0);
        chk("cnt1_busy", 32'(busy_seen), 32'd0);
        bus.state          = 3'd0;
        bus.counter_tiling = 16'd2;
        tick();

        // Re-trigger mid-stream, lanes_valid 0 clamps to 8, tile_data changed after capture
        bus.lanes_valid = 4'd0;
        bus.state       = 3'd4;
        tick();
        set_lanes(16'h100);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("retrig_data", 32'(bus.data_output), 32'(i + 1));
            chk("retrig_sel", 32'(bus.sel_data), 32'(i));
            chk("retrig_last", 32'(bus.last), 32'(i == 7));
            if (i == 2) bus.state = 3'd0;
            if (i == 3) bus.state = 3'd4;
        end
        chk("retrig_ovf_set", 32'(bus.overflow), 32'd1);
        tick();
        chk("retrig_done", 32'(bus.tile_done), 32'd1);
        chk("retrig_ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("retrig_ovf_clr", 32'(bus.overflow), 32'd0);
        chk("retrig_no_restart", 32'(bus.busy), 32'd0);
        bus.state       = 3'd0;
        bus.lanes_valid = 4'd8;
        set_lanes(1);
        tick();

        // Asynchronous reset at the 4th word
        bus.state = 3'd4;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_data", 32'(bus.data_output), 32'(i + 1));
        end
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.valid_data), 32'd0);
        chk("abort_data0", 32'(bus.data_output), 32'd0);
        chk("abort_sel", 32'(bus.sel_data), 32'd0);
        chk("abort_last", 32'(bus.last), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        bus.state = 3'd0;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_done", 32'(bus.tile_done), 32'd0);
        bus.state = 3'd4;
        tick();
        chk("restart_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("restart_valid", 32'(bus.valid_data), 32'd1);
        chk("restart_sel", 32'(bus.sel_data), 32'd0);
        chk("restart_data", 32'(bus.data_output), 32'd1);
        repeat (9) tick();
        bus.state = 3'd0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/write_data_stream.md
# write_data_stream

Parametrised tile-result writer for the fully-connected datapath. It captures one tile of `TILING_SIZE` accumulator lanes when the top controller enters its write phase, then streams the lanes one per transfer over a valid/ready handshake. Lane count per tile and stream order are run-time selectable. It replaces the fixed-length, no-backpressure tile writer between the accumulator bank and the output memory/DMA.

## Interface
- `DATA_WIDTH`, 16, width of one lane / output word
- `TILING_SIZE`, 8, lanes per tile (≥2)
- `SEL_W`, `$clog2(TILING_SIZE)`, width of lane index
- `CNT_W`, 16, width of `counter_tiling`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `state`  in  3  top-controller state; write phase is `3'd4`
- `counter_tiling`  in  CNT_W  tile counter from controller
- `tile_data`  in  TILING_SIZE*DATA_WIDTH  flat lane vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- `lanes_valid`  in  SEL_W+1  lanes to send this tile; 0 or >TILING_SIZE clamps to TILING_SIZE
- `reverse`  in  1  1 = send lanes highest-first
- `out_ready`  in  1  downstream accepts `data_output`
- `clr_err`  in  1  clears `overflow`
- `data_output`  out  DATA_WIDTH  current lane word
- `valid_data`  out  1  `data_output` valid
- `sel_data`  out  SEL_W  index of lane on `data_output`
- `last`  out  1  current word is final lane of tile
- `busy`  out  1  FSM not IDLE
- `tile_done`  out  1  one-cycle pulse after final transfer
- `overflow`  out  1  sticky: trigger dropped while busy

## Operation
- Trigger = `state==3'd4 && counter_tiling>1`; `trig_q` registers it; `start = trigger & ~trig_q` (one start per write-phase entry, not level).
- FSM: IDLE, LOAD, SEND.
  - IDLE: on `start` → LOAD; snapshot `tile_data` into internal register, latch clamped lane count N and `reverse`.
  - LOAD: one cycle, outputs idle; → SEND; `sel_data` ← 0 (forward) or N-1 (reverse).
  - SEND: `valid_data=1`. Transfer = `valid_data & out_ready`. On transfer not final: `sel_data` ±1. On final transfer (index N-1 forward, 0 reverse) → IDLE, `tile_done` ← 1 for the next cycle.
- `data_output` = snapshot lane `sel_data` when SEND, else 0; `last` = SEND & index is final.
- Without `out_ready`, `data_output`, `sel_data`, `last` hold stable; `valid_data` never drops mid-tile.
- `start` while not IDLE (including the final-transfer cycle): ignored, `overflow` ← 1. `clr_err` clears it; a set in the same cycle wins.
- Later `tile_data` changes do not affect a stream in progress.

## Timing
- Reset: all outputs 0, FSM IDLE, `trig_q`=0, snapshot 0; takes effect asynchronously, aborting any stream with no `tile_done`.
- `start` in cycle T → LOAD in T+1 → first word valid in T+2.
- With `out_ready` held 1: N words in T+2..T+N+1, `tile_done` and IDLE in T+N+2. Earliest next `start`: T+N+2.
- Each cycle of `out_ready=0` in SEND adds one cycle.
- `valid_data`, `busy`, `last`, `sel_data`, `tile_done` are register-driven or decoded from registers only. `data_output` is a mux of registers, with no combinational path from inputs to outputs.

## Test plan
- Reset then `state=4`, `counter_tiling=2`, lanes = 0x0001..0x0008, `lanes_valid=8`, `out_ready=1` → words 1..8 in T+2..T+9, `sel_data` 0..7, `last` only at 8, `tile_done` at T+10.
- Same tile, `reverse=1`, `lanes_valid=3` → words 3,2,1, `sel_data` 2,1,0, `last` on word 1.
- `out_ready` toggles 1,0,0,1… → each word held across stalls, no loss or duplication, 8 transfers total.
- Hold `state=4` for 20 cycles → exactly one tile sent. `counter_tiling=1` → nothing sent.
- Re-trigger (`state` 4→0→4) mid-stream → stream unaffected, `overflow`=1 until `clr_err`. `lanes_valid=0` → 8 lanes.
- Assert `rst` at the 4th word → all outputs 0 immediately. Next trigger restarts from lane 0.
